// File: rtl/vga_mon_pkg.sv
// rtl/vga_mon_pkg.sv - shared types, register map and helpers for the VGA timing monitor
package vga_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Read map
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_LW     = 3'd1;
    localparam logic [2:0] ADDR_FH     = 3'd2;
    localparam logic [2:0] ADDR_HTOT   = 3'd3;
    localparam logic [2:0] ADDR_VTOT   = 3'd4;
    localparam logic [2:0] ADDR_ERR    = 3'd5;
    localparam logic [2:0] ADDR_PROBE  = 3'd6;
    localparam logic [2:0] ADDR_CRC    = 3'd7;

    // Write map
    localparam logic [2:0] ADDR_PROBE_X = 3'd0;
    localparam logic [2:0] ADDR_PROBE_Y = 3'd1;
    localparam logic [2:0] ADDR_CLEAR   = 3'd2;

    localparam int CNT_W = 11;

    function automatic logic [15:0] rgb565(input logic [4:0] r5, input logic [5:0] g6,
                                           input logic [4:0] b5);
        return {r5, g6, b5};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_mon_crc16.sv
// rtl/vga_mon_crc16.sv - CRC-16/CCITT (poly 0x1021, init 0xFFFF), one 16-bit word per enable
module vga_mon_crc16
    import vga_mon_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    // Word is folded in MSB first, one bit per loop step
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Running CRC register; init has priority over a data word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 16'hFFFF;
        end else if (init) begin
            crc <= 16'hFFFF;
        end else if (en) begin
            crc <= crc_word(crc, data);
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA stream timing monitor with lock FSM, pixel probe and register port; frame CRC under VGA_MON_CRC_EN
module vga_timing_monitor
    import vga_mon_pkg::*;
#(
    parameter int EXP_W       = 640,
    parameter int EXP_H       = 480,
    parameter int EXP_HTOTAL  = 800,
    parameter int EXP_VTOTAL  = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        locked,
    output logic        frame_pulse
);

    localparam logic [CNT_W-1:0] EXP_W_C  = CNT_W'(EXP_W);
    localparam logic [CNT_W-1:0] EXP_H_C  = CNT_W'(EXP_H);
    localparam logic [CNT_W-1:0] EXP_HT_C = CNT_W'(EXP_HTOTAL);
    localparam logic [CNT_W-1:0] EXP_VT_C = CNT_W'(EXP_VTOTAL);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

    logic             vga_clk_q, hs_q, vs_q, blank_q;
    logic             ps, hs_fall, vs_fall, blank_fall;
    logic [CNT_W-1:0] col, row, htot_cnt, vtot_cnt;
    logic [CNT_W-1:0] lw, fh, htot, vtot;
    logic [CNT_W-1:0] htot_line, vtot_line, lw_eff, htot_eff;
    logic             match;
    state_t           state, state_next;
    logic [3:0]       good_cnt, good_next;
    logic             err_inc;
    logic [15:0]      err_cnt;
    logic [10:0]      probe_x;
    logic [9:0]       probe_y;
    logic             probe_valid, probe_hit, clear;
    logic [15:0]      probe_rgb, pix565, crc_frame;
    logic             unused_low_bits;

    assign unused_low_bits = ^{vga_r[2:0], vga_g[1:0], vga_b[2:0], writedata[15:11]};

    assign ps         = vga_clk & ~vga_clk_q;
    assign hs_fall    = hs_q & ~vga_hs;
    assign vs_fall    = vs_q & ~vga_vs;
    assign blank_fall = blank_q & ~vga_blank_n;
    assign pix565     = rgb565(vga_r[7:3], vga_g[7:2], vga_b[7:3]);
    assign clear      = chipselect & write & (address == ADDR_CLEAR);
    assign probe_hit  = ps & vga_blank_n & (col == probe_x) & (row == {1'b0, probe_y});
    assign locked     = (state == LOCKED);

    // One-cycle history of the stream for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_clk_q <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            vga_clk_q <= vga_clk;
            hs_q      <= vga_hs;
            vs_q      <= vga_vs;
            blank_q   <= vga_blank_n;
        end
    end

    // Values a line commits at HS fall; these are what a same-cycle VS fall must see.
    // Blanking lines carry no pixels, so they keep the last measured width.
    always_comb begin
        htot_line = ps ? sat_inc(htot_cnt) : htot_cnt;
        vtot_line = hs_fall ? sat_inc(vtot_cnt) : vtot_cnt;
        lw_eff    = (hs_fall && col != '0) ? col : lw;
        htot_eff  = hs_fall ? htot_line : htot;
        match     = (lw_eff == EXP_W_C) && (row == EXP_H_C) &&
                    (htot_eff == EXP_HT_C) && (vtot_line == EXP_VT_C);
    end

    // Per-line counters and line measurements
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col      <= '0;
            htot_cnt <= '0;
            lw       <= '0;
            htot     <= '0;
        end else if (hs_fall) begin
            col      <= '0;
            htot_cnt <= '0;
            htot     <= htot_line;
            lw       <= lw_eff;
        end else begin
            if (ps) htot_cnt <= sat_inc(htot_cnt);
            if (ps && vga_blank_n) col <= sat_inc(col);
        end
    end

    // Per-frame counters and frame measurements
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row      <= '0;
            vtot_cnt <= '0;
            fh       <= '0;
            vtot     <= '0;
        end else if (vs_fall) begin
            row      <= '0;
            vtot_cnt <= '0;
            fh       <= row;
            vtot     <= vtot_line;
        end else begin
            if (hs_fall) vtot_cnt <= sat_inc(vtot_cnt);
            if (blank_fall) row <= sat_inc(row);
        end
    end

    // Lock FSM next state; only a VS fall moves it
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_inc    = 1'b0;
        if (vs_fall) begin
            case (state)
                UNLOCKED: begin
                    state_next = ACQUIRE;
                    good_next  = 4'd0;
                end
                ACQUIRE: begin
                    if (!match) begin
                        good_next = 4'd0;
                    end else if (good_cnt + 4'd1 == LOCK_N) begin
                        state_next = LOCKED;
                        good_next  = 4'd0;
                    end else begin
                        good_next = good_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_next = ACQUIRE;
                        good_next  = 4'd0;
                        err_inc    = 1'b1;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                    good_next  = 4'd0;
                end
            endcase
        end
    end

    // Lock FSM state register and frame strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= UNLOCKED;
            good_cnt    <= 4'd0;
            frame_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            good_cnt    <= good_next;
            frame_pulse <= vs_fall;
        end
    end

    // Lock-loss counter; a host clear beats a simultaneous increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 16'h0;
        end else if (clear) begin
            err_cnt <= 16'h0;
        end else if (err_inc && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h1;
        end
    end

    // Probe coordinate registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            probe_x <= '0;
            probe_y <= '0;
        end else if (chipselect && write) begin
            if (address == ADDR_PROBE_X) probe_x <= writedata[10:0];
            if (address == ADDR_PROBE_Y) probe_y <= writedata[9:0];
        end
    end

    // Probe pixel capture, refreshed every frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            probe_rgb   <= 16'h0;
            probe_valid <= 1'b0;
        end else begin
            if (probe_hit) probe_rgb <= pix565;
            if (clear) probe_valid <= 1'b0;
            else if (probe_hit) probe_valid <= 1'b1;
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_run;

    vga_mon_crc16 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (vs_fall),
        .en      (ps & vga_blank_n),
        .data    (pix565),
        .crc     (crc_run)
    );

    // Snapshot of the running CRC at each frame boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_frame <= 16'h0;
        end else if (vs_fall) begin
            crc_frame <= crc_run;
        end
    end
`else
    assign crc_frame = 16'h0;
`endif

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0;
        end else if (chipselect && read) begin
            case (address)
                ADDR_STATUS: readdata <= {12'b0, probe_valid, locked, state};
                ADDR_LW:     readdata <= {5'b0, lw};
                ADDR_FH:     readdata <= {5'b0, fh};
                ADDR_HTOT:   readdata <= {5'b0, htot};
                ADDR_VTOT:   readdata <= {5'b0, vtot};
                ADDR_ERR:    readdata <= err_cnt;
                ADDR_PROBE:  readdata <= probe_rgb;
                ADDR_CRC:    readdata <= crc_frame;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - self-checking bench for vga_timing_monitor (reduced frame geometry)
module tb_vga_timing_monitor;

    localparam int W        = 16;
    localparam int H        = 10;
    localparam int HT       = 24;
    localparam int VT       = 16;
    localparam int HS_START = W + 2;
    localparam int HS_LEN   = 3;
    localparam int VS_LINE  = H + 2;
    localparam int PX       = 5;
    localparam int PY       = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vga_clk = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic [7:0]  vga_r = 8'h0;
    logic [7:0]  vga_g = 8'h0;
    logic [7:0]  vga_b = 8'h0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [15:0] writedata = 16'h0;
    logic [15:0] readdata;
    logic        locked;
    logic        frame_pulse;

    vga_timing_monitor #(
        .EXP_W(W), .EXP_H(H), .EXP_HTOTAL(HT), .EXP_VTOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .locked(locked), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp;
        string       name;
    } rd_t;

    rd_t sb_q[$];
    rd_t tbl[8];
    int  errors = 0;
    int  checks = 0;

    int  gen_frame = 0;
    int  gen_v = 0;
    int  gen_h = 0;
    int  short_at = -1;
    bit  gen_en = 1'b0;
    bit  probe_red = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_read(input logic [2:0] a, input logic [15:0] exp, input string name);
        rd_t e;
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        e.addr = a; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0;
        e = sb_q.pop_front();
        chk(e.name, {16'h0, readdata}, {16'h0, e.exp});
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_pulse && n < 4000);
        checks++;
        if (!frame_pulse) begin
            errors++;
            $display("FAIL %s: no frame_pulse within %0d cycles", name, n);
        end
    endtask

    task automatic wait_pos(input int f, input int v, input int h, input string name);
        int n;
        n = 0;
        while (!((f < 0 || gen_frame == f) && gen_v == v && gen_h == h) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!((f < 0 || gen_frame == f) && gen_v == v && gen_h == h)) begin
            errors++;
            $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", name, v, h, gen_v, gen_h);
        end
    endtask

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc_ref(input bit with_red);
        logic [15:0] c;
        logic [15:0] w;
        logic [7:0]  by;
        c = 16'hFFFF;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                w = (with_red && v == PY && h == PX) ? 16'hF800 : 16'h0000;
                for (int k = 0; k < 2; k++) begin
                    by = (k == 0) ? w[15:8] : w[7:0];
                    c = c ^ {by, 8'h00};
                    for (int b = 0; b < 8; b++) begin
                        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
                    end
                end
            end
        end
        return c;
    endfunction
`endif

    // Stream source: one pixel per two clk, new values presented with the vga_clk rise
    initial begin
        int vt;
        wait (gen_en);
        forever begin
            vt = (gen_frame == short_at) ? VT - 1 : VT;
            for (int v = 0; v < vt; v++) begin
                for (int h = 0; h < HT; h++) begin
                    @(negedge clk);
                    gen_v = v;
                    gen_h = h;
                    vga_clk = 1'b1;
                    vga_hs = !(h >= HS_START && h < HS_START + HS_LEN);
                    vga_vs = !((v == VS_LINE && h >= HS_START) || (v == VS_LINE + 1 && h < HS_START));
                    vga_blank_n = (h < W) && (v < H);
                    if (probe_red && v == PY && h == PX) begin
                        vga_r = 8'hFF; vga_g = 8'h00; vga_b = 8'h00;
                    end else begin
                        vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
                    end
                    @(negedge clk);
                    vga_clk = 1'b0;
                end
            end
            gen_frame++;
        end
    end

    initial begin
        #700000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int target;

        tbl[0] = '{3'd0, 16'h000E, "status_locked"};
        tbl[1] = '{3'd1, 16'(W),   "line_width"};
        tbl[2] = '{3'd2, 16'(H),   "frame_height"};
        tbl[3] = '{3'd3, 16'(HT),  "htotal"};
        tbl[4] = '{3'd4, 16'(VT),  "vtotal"};
        tbl[5] = '{3'd5, 16'h0000, "err_cnt_zero"};
        tbl[6] = '{3'd6, 16'hF800, "probe_rgb"};
`ifdef VGA_MON_CRC_EN
        tbl[7] = '{3'd7, crc_ref(1'b1), "crc_frame"};
`else
        tbl[7] = '{3'd7, 16'h0000, "crc_disabled"};
`endif

        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_readdata", {16'h0, readdata}, 32'h0);
        chk("reset_locked", {31'h0, locked}, 32'h0);
        chk("reset_frame_pulse", {31'h0, frame_pulse}, 32'h0);
        reset_n = 1'b1;
        reg_read(3'd0, 16'h0000, "status_after_reset");
        reg_write(3'd0, 16'(PX));
        reg_write(3'd1, 16'(PY));
        gen_en = 1'b1;

        wait_frame("lock_f1"); chk("locked_f1", {31'h0, locked}, 32'h0);
        wait_frame("lock_f2"); chk("locked_f2", {31'h0, locked}, 32'h0);
        wait_frame("lock_f3"); chk("locked_f3", {31'h0, locked}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            reg_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end

        // One short frame: still locked at the next VS, dropped at the one after
        short_at = gen_frame + 1;
        wait_frame("bad_f1"); chk("locked_before_bad", {31'h0, locked}, 32'h1);
        wait_frame("bad_f2"); chk("locked_drop", {31'h0, locked}, 32'h0);
        reg_read(3'd5, 16'h0001, "err_cnt_one");
        reg_read(3'd0, 16'h0009, "status_acquire");
        reg_read(3'd4, 16'(VT - 1), "vtotal_short");
        wait_frame("relock_f1"); chk("relock_f1", {31'h0, locked}, 32'h0);
        wait_frame("relock_f2"); chk("relock_f2", {31'h0, locked}, 32'h1);

        // Clear written in the very cycle the mismatching frame ends
        short_at = gen_frame + 1;
        target   = gen_frame + 2;
        wait_pos(target, VS_LINE, HS_START - 1, "clear_race_pos");
        @(negedge clk);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 3'd2; writedata = 16'h0;
        @(posedge clk);
        #1;
        chk("clear_race_pulse", {31'h0, frame_pulse}, 32'h1);
        chk("clear_race_locked", {31'h0, locked}, 32'h0);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        reg_read(3'd5, 16'h0000, "err_cnt_cleared");
        reg_read(3'd0, 16'h0001, "status_cleared");

        // Reset mid-line in an active row
        wait_pos(-1, 5, 3, "midreset_pos");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_readdata", {16'h0, readdata}, 32'h0);
        chk("midreset_locked", {31'h0, locked}, 32'h0);
        chk("midreset_frame_pulse", {31'h0, frame_pulse}, 32'h0);
        wait_pos(-1, 5, W + 1, "midreset_release_pos");
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(3'd0, 16'h0000, "status_after_midreset");
        wait_frame("reacq_f1"); chk("reacq_f1", {31'h0, locked}, 32'h0);
        wait_frame("reacq_f2"); chk("reacq_f2", {31'h0, locked}, 32'h0);
        wait_frame("reacq_f3"); chk("reacq_f3", {31'h0, locked}, 32'h1);

`ifdef VGA_MON_CRC_EN
        probe_red = 1'b0;
        wait_frame("crc_zero_frame");
        reg_read(3'd7, crc_ref(1'b0), "crc_zero_frame");
        probe_red = 1'b1;
`else
        reg_read(3'd7, 16'h0000, "crc_disabled_late");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
